// File: rtl/fetch_sequencer_if.sv
// Instruction-memory handshake bundle between the fetch sequencer and memory.
// The sequencer presents a request and an address; memory answers with a ready
// strobe and the instruction word, which is valid in the same cycle as ready.
interface fetch_sequencer_if #(
   parameter int unsigned PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;

   // Sequencer side: issues requests, consumes the returned word.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   // Memory side: observes requests, returns ready and data.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for a single-cycle RISC-V core.
// Owns the PC, runs the request/ready handshake with instruction memory,
// latches the returned word, and selects the next PC (sequential, redirect,
// or hold). Tracks completed fetches, PC wrap-around and memory timeouts.
// Once HALTED the block only leaves via reset.
module fetch_sequencer #(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     INC      = 4,
   parameter int unsigned     MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic                halt_req_i,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [PC_W-1:0]     redirect_pc_i,
   fetch_sequencer_if.master   imem,
   output logic [PC_W-1:0]     pc_o,
   output logic [31:0]         instr_o,
   output logic                instr_valid_o,
   output logic                pc_wrap_o,
   output logic                fetch_err_o,
   output logic [15:0]         instr_count_o
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              pc_wrap_q, pc_wrap_d;
   logic              fetch_err_q, fetch_err_d;
   logic [15:0]       instr_count_q, instr_count_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Sequential next PC with one extra bit; the carry only feeds pc_wrap.
   logic [PC_W:0]     pc_sum;
   logic [PC_W-1:0]   redirect_aligned;
   logic [WAIT_W-1:0] wait_inc;

   assign pc_sum           = {1'b0, pc_q} + (PC_W + 1)'(INC);
   // Redirect targets are word aligned: the two low bits are dropped.
   assign redirect_aligned = redirect_pc_i & ~(PC_W'(3));
   assign wait_inc         = wait_q + 1'b1;

   // Next-state and datapath selection; every target defaults to hold.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      pc_wrap_d     = pc_wrap_q;
      fetch_err_d   = fetch_err_q;
      instr_count_d = instr_count_q;
      wait_d        = '0;   // cleared whenever we are not waiting in FETCH

      case (state_q)
         ST_IDLE: begin
            // halt_req wins over start, matching the EXEC priority order.
            if (halt_req_i) begin
               state_d = ST_HALTED;
            end else if (start_i) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            // Control inputs are ignored here; only the memory answer matters.
            if (imem.imem_ready) begin
               instr_d       = imem.imem_rdata;
               instr_valid_d = 1'b1;
               if (instr_count_q != 16'hFFFF) begin
                  instr_count_d = instr_count_q + 16'd1;
               end
               state_d = ST_EXEC;
            end else begin
               wait_d = wait_inc;
               if (wait_inc == WAIT_W'(MAX_WAIT)) begin
                  fetch_err_d = 1'b1;
                  state_d     = ST_HALTED;
               end
            end
         end

         ST_EXEC: begin
            if (halt_req_i) begin
               state_d = ST_HALTED;
            end else if (stall_i) begin
               state_d = ST_EXEC;
            end else if (redirect_i) begin
               pc_d    = redirect_aligned;
               state_d = ST_FETCH;
            end else begin
               pc_d = pc_sum[PC_W-1:0];
               if (pc_sum[PC_W]) begin
                  pc_wrap_d = 1'b1;
               end
               state_d = ST_FETCH;
            end
         end

         ST_HALTED: begin
            state_d = ST_HALTED;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         pc_wrap_q     <= 1'b0;
         fetch_err_q   <= 1'b0;
         instr_count_q <= '0;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         pc_wrap_q     <= pc_wrap_d;
         fetch_err_q   <= fetch_err_d;
         instr_count_q <= instr_count_d;
         wait_q        <= wait_d;
      end
   end

   // Request is a pure decode of the state register; address tracks the PC.
   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;

   assign pc_o          = pc_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign pc_wrap_o     = pc_wrap_q;
   assign fetch_err_o   = fetch_err_q;
   assign instr_count_o = instr_count_q;

endmodule
